// File: rtl/shift_issue_queue.sv
// Command FIFO feeding a combinational logical-right shifter, with a registered valid/ready result stage.
// Optional SHIFT_ISSUE_QUEUE_STATS_EN adds done_cnt (handshake counter) and full_stall (sticky overflow-attempt flag).
module shift_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int MAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_op,
  input  logic [MAG_W-1:0]         in_mag,
  output logic [DATA_W-1:0]        sh_op,
  output logic [MAG_W-1:0]         sh_mag,
  input  logic [DATA_W-1:0]        sh_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
  ,
  output logic [15:0]              done_cnt,
  output logic                     full_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DATA_W + MAG_W;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic              push, cap, not_empty;
  logic [EW-1:0]     head;

  assign not_empty = (count_reg != '0);
  assign in_ready  = (count_reg < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign cap       = not_empty & (~out_valid_reg | out_ready);

  // Head is read asynchronously so the shifter sees it in the same cycle.
  assign head   = mem[rd_ptr_reg];
  assign sh_op  = not_empty ? head[EW-1:MAG_W] : '0;
  assign sh_mag = not_empty ? head[MAG_W-1:0]  : '0;

  // Storage carries no reset; emptiness is tracked purely by count_reg.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && wr_ptr_reg == PW'(gi))
          mem[gi] <= {in_op, in_mag};
      end
    end
  endgenerate

  always_comb begin
    count_next     = count_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    if (push && !cap)
      count_next = count_reg + 1'b1;
    else if (cap && !push)
      count_next = count_reg - 1'b1;
    if (cap) begin
      out_valid_next = 1'b1;
      out_data_next  = sh_result;
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (cap)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign count     = count_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
  logic [15:0] done_cnt_reg;
  logic        full_stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_reg   <= '0;
      full_stall_reg <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready)
        done_cnt_reg <= done_cnt_reg + 16'd1;
      if (in_valid && !in_ready)
        full_stall_reg <= 1'b1;
    end
  end

  assign done_cnt   = done_cnt_reg;
  assign full_stall = full_stall_reg;
`endif

endmodule
